// File: rtl/approx_error_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: FSM state
// encoding, default operand/accumulator widths and the error-width rule.
// No ports; imported by approx_err_stage and approx_error_monitor.
package approx_error_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_ACC_W = 48;

   // Signed error of a (WIDTH+1)-bit approximate sum against the exact
   // (WIDTH+1)-bit sum needs one extra bit for the sign.
   function automatic int err_w(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Stage 1 of the error monitor: exact add, signed error and |error|, registered.
// Ports: i_vld/i_a/i_b/i_approx = accepted sample; o_vld/o_err/o_abs = registered
// result one cycle later. o_vld follows i_vld only, so idle cycles leave no trace.
module approx_err_stage
   import approx_error_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_vld,
   input  logic [WIDTH-1:0]       i_a,
   input  logic [WIDTH-1:0]       i_b,
   input  logic [WIDTH:0]         i_approx,
   output logic                   o_vld,
   output logic signed [WIDTH+1:0] o_err,
   output logic [WIDTH+1:0]       o_abs
);

   localparam int EW = err_w(WIDTH);

   logic [WIDTH:0]        w_exact;
   logic signed [EW-1:0]  w_err;
   logic [EW-1:0]         w_abs;

   // Exact sum keeps the carry; both operands of the subtraction are
   // zero-extended so the difference can never wrap.
   assign w_exact = {1'b0, i_a} + {1'b0, i_b};
   assign w_err   = $signed({1'b0, i_approx}) - $signed({1'b0, w_exact});
   // The most negative EW-bit value is unreachable, so negation is safe.
   assign w_abs   = w_err[EW-1] ? (~w_err + 1'b1) : w_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_vld <= 1'b0;
         o_err <= '0;
         o_abs <= '0;
      end else begin
         o_vld <= i_vld;
         if (i_vld) begin
            o_err <= w_err;
            o_abs <= w_abs;
         end
      end
   end

endmodule

// File: rtl/approx_error_monitor.sv
// Measures the error of an approximate adder over a run of n_samples samples:
// sum of squared error (saturating), max |error| and count of erroneous samples.
// Ports: start/n_samples begin a run; in_valid/in_ready + in_a/in_b/in_approx
// carry samples; busy/done report progress; sse/max_abs_err/err_count/sse_sat
// are the results, held stable while done is high.
module approx_error_monitor
   import approx_error_monitor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      n_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH:0]   in_approx,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] sse,
   output logic [WIDTH+1:0] max_abs_err,
   output logic [15:0]      err_count,
   output logic             sse_sat
);

   localparam int EW    = err_w(WIDTH);
   localparam int SQ_W  = 2 * EW;
   // Adder wide enough for both the accumulator and a full square, plus carry.
   localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

   state_t r_state;
   state_t w_next;

   logic [15:0]          r_n;
   logic [15:0]          r_acc_cnt;

   logic                 w_s1_vld;
   logic signed [EW-1:0] w_s1_err;
   logic [EW-1:0]        w_s1_abs;

   logic                 r_s2_vld;
   logic [SQ_W-1:0]      r_s2_sq;
   logic [EW-1:0]        r_s2_abs;
   logic                 r_s2_nz;

   logic [ACC_W-1:0]     r_sse;
   logic [EW-1:0]        r_max;
   logic [15:0]          r_cnt;
   logic                 r_sat;

   logic                 w_accept;
   logic                 w_start_ok;
   logic                 w_last;
   logic [SUM_W-1:0]     w_sum;
   logic [SUM_W-1:0]     w_acc_max;
   logic                 w_sum_ovf;

   assign w_accept   = in_valid & in_ready;
   assign w_start_ok = start & ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last     = w_accept && (r_acc_cnt == (r_n - 16'd1));

   approx_err_stage #(.WIDTH(WIDTH)) u_stage1 (
      .clk      (clk),
      .rst      (rst),
      .i_vld    (w_accept),
      .i_a      (in_a),
      .i_b      (in_b),
      .i_approx (in_approx),
      .o_vld    (w_s1_vld),
      .o_err    (w_s1_err),
      .o_abs    (w_s1_abs)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_next = (n_samples == 16'd0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Done only once both pipeline stages have retired their samples.
            if (!w_s1_vld && !r_s2_vld) w_next = ST_DONE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (r_state == ST_RUN) && (r_acc_cnt < r_n);
      busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
      done     = (r_state == ST_DONE);
   end

   // ---------------- Accumulation ----------------
   assign w_acc_max = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
   assign w_sum     = SUM_W'(r_sse) + SUM_W'(r_s2_sq);
   assign w_sum_ovf = (w_sum > w_acc_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n       <= '0;
         r_acc_cnt <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_sq   <= '0;
         r_s2_abs  <= '0;
         r_s2_nz   <= 1'b0;
         r_sse     <= '0;
         r_max     <= '0;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_n       <= n_samples;
            r_acc_cnt <= '0;
         end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
         end

         // Stage 2: square the magnitude.
         r_s2_vld <= w_s1_vld;
         if (w_s1_vld) begin
            r_s2_sq  <= SQ_W'(w_s1_abs) * SQ_W'(w_s1_abs);
            r_s2_abs <= w_s1_abs;
            r_s2_nz  <= (w_s1_err != '0);
         end

         // Result registers; a start is only honoured while the pipeline is
         // empty, so clearing and accumulating never coincide.
         if (w_start_ok) begin
            r_sse <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (r_s2_vld) begin
            if (w_sum_ovf) begin
               r_sse <= '1;
               r_sat <= 1'b1;
            end else begin
               r_sse <= w_sum[ACC_W-1:0];
            end
            if (r_s2_abs > r_max) r_max <= r_s2_abs;
            if (r_s2_nz && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign sse         = r_sse;
   assign max_abs_err = r_max;
   assign err_count   = r_cnt;
   assign sse_sat     = r_sat;

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter WIDTH, default 16, operand width; approximate sum is WIDTH+1 bits.
REQ-002 Parameter ACC_W, default 48, width of the sum-of-squared-error accumulator.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse, begins a measurement run; honoured only in IDLE or DONE.
REQ-006 n_samples  input  16  samples per run, sampled on the accepted start; 0 = empty run.
REQ-007 in_valid / in_ready  input / output  1 / 1  sample handshake; a sample transfers when both are high.
REQ-008 in_a, in_b  input  WIDTH  operands fed to the adder under test.
REQ-009 in_approx  input  WIDTH+1  output of the adder under test for in_a, in_b.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE; results valid and stable.
REQ-012 sse  output  ACC_W  sum over the run of (in_approx - (in_a+in_b))^2, saturating at all-ones.
REQ-013 max_abs_err  output  WIDTH+2  largest |in_approx - exact| in the run.
REQ-014 err_count  output  16  number of samples with nonzero error.
REQ-015 sse_sat  output  1  sticky; set when sse saturated during the run.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE/DONE + start, n_samples != 0 -> RUN; clear sse, max_abs_err, err_count, sse_sat and the accepted-sample counter in that cycle.
REQ-018 IDLE/DONE + start, n_samples == 0 -> DONE with all results zero.
REQ-019 in_ready = 1 only in RUN while accepted count < n_samples; start in RUN/DRAIN ignored.
REQ-020 RUN -> DRAIN in the cycle the n_samples-th sample is accepted; DRAIN -> DONE once the pipeline is empty.
REQ-021 Exact sum computed at full WIDTH+1 bits; error = in_approx - exact as signed WIDTH+2 bits, no truncation.
REQ-022 Pipeline: stage 1 registers signed error and |error|; stage 2 squares |error| (2*WIDTH+4 bits) and updates sse, max_abs_err, err_count.
REQ-023 done rises exactly 3 cycles after the clock edge accepting the last sample; no bubbles required between samples.
REQ-024 Stage-1 and stage-2 valid bits follow accepted samples only; in_valid with in_ready low has no effect.
REQ-025 sse addition saturates to 2^ACC_W-1 and sets sse_sat; further adds keep the saturated value.
REQ-026 err_count saturates at 65535.
REQ-027 Results hold unchanged in DONE until the next accepted start.

Reset
REQ-028 rst asserted: state IDLE; in_ready, busy, done, sse, max_abs_err, err_count, sse_sat, counters and pipeline valids = 0, immediately and asynchronously.
REQ-029 rst mid-run aborts the run; no partial results retained; next start starts clean.

Structure
REQ-030 Shared package holds FSM state enum, default WIDTH/ACC_W constants and the error-width expression WIDTH+2.
REQ-031 One sub-module, approx_err_stage, holds the exact add and signed/absolute error computation (stage 1); FSM and accumulation remain in the top.

Verification
REQ-032 start, n_samples=1; a=1, b=1, approx=3 -> 3 cycles later done=1, sse=1, max_abs_err=1, err_count=1.
REQ-033 n_samples=4, back-to-back exact samples (approx=a+b incl. 16'hFFFF+16'hFFFF=17'h1FFFE) -> sse=0, err_count=0, done 3 cycles after 4th accept.
REQ-034 n_samples=2; approx=0 with a=b=16'hFFFF, then error -3 -> max_abs_err=131070, sse=131070^2+9, err_count=2.
REQ-035 ACC_W=8, n_samples=2, errors 15 and 15 -> sse=255, sse_sat=1.
REQ-036 rst asserted after 2 of 5 samples -> all outputs 0 next cycle; new start n_samples=1, error 0 -> sse=0, err_count=0.
REQ-037 start with n_samples=0 -> DONE next cycle, results 0, in_ready never high; in_valid toggling with in_ready low changes nothing.
